// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the eight-source interrupt scheduler.
package irq_sched_pkg;

  localparam int NSRC = 8;
  localparam int ID_W = 3;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_e;

  // Vector word for a source; the sum wraps modulo 2^32.
  function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + {27'd0, id, 2'b00};
  endfunction

endpackage

// File: rtl/irq_pri_enc.sv
// Fixed-priority encoder: the highest set index of the eligible vector wins.
module irq_pri_enc
  import irq_sched_pkg::*;
(
  input  logic [NSRC-1:0] eligible,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge capture into pending, fixed-priority pick, and
// request/ack/eoi handshake driving the vector onto the operand path.
module irq_sched
  import irq_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            int_en,
  input  logic            int_ack,
  input  logic            eoi,
  output logic            int_req,
  output logic [ID_W-1:0] int_id,
  output logic [31:0]     int_vec,
  output logic            vec_sel,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     vec_q, vec_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] eligible;
  logic [ID_W-1:0] win_id;
  logic            win_vld;

  assign rise     = irq & ~irq_prev_q;
  assign eligible = pending_q & irq_mask;

  irq_pri_enc u_pri_enc (
    .eligible (eligible),
    .id       (win_id),
    .valid    (win_vld)
  );

  always_comb begin
    state_d      = state_q;
    clr          = '0;
    in_service_d = in_service_q;
    id_d         = id_q;
    vec_d        = vec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (int_en && win_vld) begin
          id_d    = win_id;
          vec_d   = vec_of(win_id);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Acknowledge beats a same-cycle drop of the global enable.
        if (int_ack) begin
          clr          = NSRC'(1) << id_q;
          in_service_d = NSRC'(1) << id_q;
          state_d      = ST_SERVICE;
        end else if (!int_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          in_service_d = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new rise on the bit being acknowledged must survive the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      id_q         <= '0;
      vec_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      id_q         <= id_d;
      vec_q        <= vec_d;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign vec_sel    = (state_q == ST_REQ);
  assign busy       = (state_q != ST_IDLE);
  assign int_id     = id_q;
  assign int_vec    = vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: doc/irq_sched.md
# irq_sched

Eight-source interrupt scheduler for the processor datapath. It captures rising edges on interrupt request lines and holds them as pending. It arbitrates pending, enabled sources by fixed priority, where the highest index wins. It then runs a request/acknowledge/end-of-interrupt handshake with the core and drives the vector onto the operand path, producing the select and 32-bit vector word that feed the datapath mux.

## Interface
- VEC_BASE, 32'h0000_0100, vector base address; vector = VEC_BASE + (id << 2)
- NSRC, 8, number of sources; fixed at 8, the id is 3 bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- irq  in  8  request lines, level, synchronous to clk
- irq_mask  in  8  per-source enable (1 = may be scheduled)
- int_en  in  1  global interrupt enable
- int_ack  in  1  core accepts the presented interrupt
- eoi  in  1  core finished servicing the current interrupt
- int_req  out  1  interrupt presented to core
- int_id  out  3  id of presented/in-service source
- int_vec  out  32  vector word for int_id
- vec_sel  out  1  datapath select: 1 routes int_vec onto operand bus
- pending  out  8  captured, not yet acknowledged requests
- in_service  out  8  one-hot source being serviced, else 0
- busy  out  1  state != IDLE

## Operation
- Edge capture: irq_prev register. rise = irq & ~irq_prev. pending <= (pending & ~clr) | rise.
  - Set wins over clear for the same bit in the same cycle.
  - Masked sources still capture pending; they are simply not eligible.
- Eligible = pending & irq_mask. Winner = highest set index of eligible.
- States: IDLE, REQ, SERVICE.
- IDLE:
  - If int_en && |eligible: latch int_id = winner and int_vec = VEC_BASE + {winner,2'b00}, then go to REQ.
  - Otherwise stay in IDLE.
- REQ: int_req=1 and vec_sel=1. int_id/int_vec are frozen; no preemption by a higher source arriving.
  - int_ack=1: clr bit int_id of pending, set in_service[int_id], go to SERVICE.
  - Else if int_en=0: withdraw to IDLE; pending is retained.
  - int_ack takes priority over int_en falling in the same cycle.
- SERVICE: int_req=0 and vec_sel=0.
  - eoi=1: in_service cleared to 0, go to IDLE.
  - No nesting; new requests accumulate in pending.
- int_ack outside REQ and eoi outside SERVICE are ignored with no state change.
- int_id/int_vec hold their last latched value outside REQ.
- Arithmetic: vector sum is 32-bit, wraps modulo 2^32, no overflow flag.

## Timing
- Reset (rst=1 at a clk edge): state=IDLE; pending, in_service, irq_prev = 0; int_req, vec_sel, busy = 0; int_id=0; int_vec=0.
- rst mid-REQ or mid-SERVICE aborts the handshake; all captured requests are lost.
- irq already high when reset releases counts as a rise on the first post-reset edge.
- Latency: irq samples high at edge k → pending bit visible after k → int_req visible after edge k+1 (if eligible and FSM in IDLE).
- int_ack sampled at edge m → int_req low, in_service set after m.
- eoi at edge e → IDLE after e. The earliest next int_req is visible after edge e+1.
  - Back-to-back throughput: minimum 3 cycles per interrupt (REQ, SERVICE, IDLE).
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Package irq_sched_pkg holds:
  - state enum (IDLE, REQ, SERVICE)
  - NSRC and id width localparams
  - function vec_of(id) returning VEC_BASE + {id,2'b00}
- Sub-module irq_pri_enc: 8-bit eligible in; 3-bit id plus valid out; combinational; highest index wins; valid=0 when input is 0.
- Top module irq_sched: edge capture, pending/in_service registers, FSM.

## Test plan
- Reset with irq=8'h00, then irq[3] pulse, mask=8'hFF, int_en=1 → int_req high 2 edges later, int_id=3, int_vec=32'h0000_010C, vec_sel=1.
- irq=8'h24 rising together → int_id=5 served first; after ack+eoi, int_id=2 presented with int_vec=32'h0000_0108.
- In REQ for id 2, irq[7] rises → int_id stays 2 until ack; id 7 is presented after eoi.
- irq[6] rises with mask[6]=0 → pending=8'h40, int_req stays 0. Then set mask=8'hFF → int_req presents id 6.
- In REQ, drop int_en with int_ack=0 → IDLE, pending bit kept. Re-enable → same id re-presented.
- irq[1] re-rises on the int_ack cycle for id 1 → pending[1] remains 1. rst asserted in SERVICE → all outputs 0 next edge.
